// File: rtl/mem_axi_bridge_pkg.sv
// Shared encodings for the data-side AXI4-Lite bridge: FSM states and AXI response codes.
package mem_axi_bridge_pkg;

    typedef enum logic [2:0] {
        MB_IDLE    = 3'd0,
        MB_WR_REQ  = 3'd1,
        MB_WR_RESP = 3'd2,
        MB_RD_REQ  = 3'd3,
        MB_RD_RESP = 3'd4,
        MB_DONE    = 3'd5
    } mb_state_t;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != AXI_RESP_OKAY;
    endfunction

endpackage

// File: rtl/mem_axi_bridge_axi_wr_track.sv
// Independent AW/W channel tracking for one write: each valid drops on its own handshake,
// both_done fires in the cycle the second handshake completes.
module axi_wr_track (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic awready,
    input  logic wready,
    output logic awvalid,
    output logic wvalid,
    output logic both_done
);

    logic aw_done_q, w_done_q;
    logic aw_hs, w_hs;

    // Valids come from registered state only, never from the ready inputs.
    assign awvalid   = active & ~aw_done_q;
    assign wvalid    = active & ~w_done_q;
    assign aw_hs     = awvalid & awready;
    assign w_hs      = wvalid & wready;
    assign both_done = active & (aw_done_q | aw_hs) & (w_done_q | w_hs);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else if (!active || both_done) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            aw_done_q <= aw_done_q | aw_hs;
            w_done_q  <= w_done_q | w_hs;
        end
    end

endmodule

// File: rtl/mem_axi_bridge.sv
// Core EX-stage load/store port to AXI4-Lite master, one transaction at a time.
// Optional MEM_BRIDGE_ERR_EN: non-OKAY responses set a sticky bus_err.
module mem_axi_bridge
    import mem_axi_bridge_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int STRB_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_rd_en,
    input  logic              mem_wr_en,
    input  logic [ADDR_W-1:0] addr_mem_rd,
    input  logic [ADDR_W-1:0] addr_mem_wr,
    input  logic [DATA_W-1:0] data_mem_wr,
    input  logic [STRB_W-1:0] strb_mem_wr,
    output logic [DATA_W-1:0] data_mem,
    output logic              stall_mem,
    output logic              bus_err,
    output logic [ADDR_W-1:0] awaddr,
    output logic [2:0]        awprot,
    output logic              awvalid,
    input  logic              awready,
    output logic [DATA_W-1:0] wdata,
    output logic [STRB_W-1:0] wstrb,
    output logic              wvalid,
    input  logic              wready,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready,
    output logic [ADDR_W-1:0] araddr,
    output logic [2:0]        arprot,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready
);

    mb_state_t         state, state_nx;
    logic [ADDR_W-1:0] wr_addr_q, rd_addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0] wstrb_q;
    logic              rd_pend_q;
    logic              start;
    logic              wr_both_done;

    assign start  = (state == MB_IDLE) && (mem_rd_en || mem_wr_en);
    assign awaddr = wr_addr_q;
    assign wdata  = wdata_q;
    assign wstrb  = wstrb_q;
    assign araddr = rd_addr_q;
    assign awprot = 3'b000;
    assign arprot = 3'b000;

    axi_wr_track u_wr_track (
        .clk       (clk),
        .rst       (rst),
        .active    (state == MB_WR_REQ),
        .awready   (awready),
        .wready    (wready),
        .awvalid   (awvalid),
        .wvalid    (wvalid),
        .both_done (wr_both_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= MB_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        stall_mem = 1'b1;
        arvalid   = 1'b0;
        rready    = 1'b0;
        bready    = 1'b0;
        case (state)
            MB_IDLE: begin
                stall_mem = mem_rd_en | mem_wr_en;
                if (mem_wr_en)      state_nx = MB_WR_REQ;
                else if (mem_rd_en) state_nx = MB_RD_REQ;
            end
            MB_WR_REQ: if (wr_both_done) state_nx = MB_WR_RESP;
            MB_WR_RESP: begin
                bready = 1'b1;
                // A combined store+load runs its read straight after the write response.
                if (bvalid) state_nx = rd_pend_q ? MB_RD_REQ : MB_DONE;
            end
            MB_RD_REQ: begin
                arvalid = 1'b1;
                if (arready) state_nx = MB_RD_RESP;
            end
            MB_RD_RESP: begin
                rready = 1'b1;
                if (rvalid) state_nx = MB_DONE;
            end
            MB_DONE: begin
                stall_mem = 1'b0;
                state_nx  = MB_IDLE;
            end
            default: state_nx = MB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_addr_q <= '0;
            rd_addr_q <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rd_pend_q <= 1'b0;
        end else if (start) begin
            wr_addr_q <= addr_mem_wr;
            rd_addr_q <= addr_mem_rd;
            wdata_q   <= data_mem_wr;
            wstrb_q   <= strb_mem_wr;
            rd_pend_q <= mem_wr_en & mem_rd_en;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                data_mem <= '0;
        else if (state == MB_RD_RESP && rvalid) data_mem <= rdata;
    end

`ifdef MEM_BRIDGE_ERR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            bus_err <= 1'b0;
        else if ((state == MB_WR_RESP && bvalid && resp_is_err(bresp)) ||
                 (state == MB_RD_RESP && rvalid && resp_is_err(rresp)))
            bus_err <= 1'b1;
    end
`else
    logic unused_resp;
    assign unused_resp = ^{bresp, rresp};
    assign bus_err     = 1'b0;
`endif

endmodule

// File: tb/tb_mem_axi_bridge.sv
// Randomized bench for mem_axi_bridge: AXI4-Lite slave with per-transaction delays and a
// reference model of stall length, bus contents, read data and sticky error.
module tb_mem_axi_bridge;

    logic        clk, rst, mem_rd_en, mem_wr_en;
    logic [63:0] addr_mem_rd, addr_mem_wr, data_mem_wr, data_mem;
    logic [7:0]  strb_mem_wr;
    logic        stall_mem, bus_err;
    logic [63:0] awaddr, wdata, araddr, rdata;
    logic [7:0]  wstrb;
    logic [2:0]  awprot, arprot;
    logic [1:0]  bresp, rresp;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;

    mem_axi_bridge dut (
        .clk(clk), .rst(rst), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
        .addr_mem_rd(addr_mem_rd), .addr_mem_wr(addr_mem_wr),
        .data_mem_wr(data_mem_wr), .strb_mem_wr(strb_mem_wr),
        .data_mem(data_mem), .stall_mem(stall_mem), .bus_err(bus_err),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec = 0, n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // slave model state
    bit          aw_f, w_f, ar_f, b_f, r_f, p_aw, p_w, p_ar;
    bit          aw_got, w_got, ar_got, b_iss, wr_open, rd_open;
    int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    int          aw_dly, w_dly, ar_dly, b_dly, r_dly;
    logic [63:0] aw_obs, w_obs, ar_obs, rdata_v, exp_data;
    logic [7:0]  s_obs;
    logic [1:0]  bresp_v, rresp_v;
    bit          exp_err;

    task automatic slave_reset();
        {aw_f, w_f, ar_f, b_f, r_f, p_aw, p_w, p_ar} = '0;
        {aw_got, w_got, ar_got, b_iss, wr_open, rd_open} = '0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
        awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
        bresp = 0; rresp = 0; rdata = 0;
    endtask

    // One slave step per falling edge; handshakes decided here land on the next rising edge.
    task automatic slave_step();
        if (rst) begin
            slave_reset();
            return;
        end
        if (aw_f) begin aw_got = 1; wr_open = 1; end
        if (w_f)  begin w_got = 1;  wr_open = 1; end
        if (ar_f) begin ar_got = 1; rd_open = 1; r_cnt = 0; end
        if (b_f)  begin bvalid = 0; aw_got = 0; w_got = 0; wr_open = 0; b_cnt = 0; b_iss = 0; end
        if (r_f)  begin rvalid = 0; rd_open = 0; end
        if (p_aw) chk("awvalid_hold_drop", 64'(awvalid), 64'(!aw_f));
        if (p_w)  chk("wvalid_hold_drop", 64'(wvalid), 64'(!w_f));
        if (p_ar) chk("arvalid_hold_drop", 64'(arvalid), 64'(!ar_f));
        if (bready)  chk("bready_after_aw_w", 64'(aw_got & w_got), 64'd1);
        if (rready)  chk("rready_after_ar", 64'(rd_open), 64'd1);
        if (arvalid) chk("ar_after_b", 64'(wr_open), 64'd0);
        if (aw_got && w_got && !b_iss) begin
            if (b_cnt >= b_dly) begin bvalid = 1; bresp = bresp_v; b_iss = 1; end
            else b_cnt++;
        end
        if (ar_got && !rvalid) begin
            if (r_cnt >= r_dly) begin rvalid = 1; rdata = rdata_v; rresp = rresp_v; ar_got = 0; end
            else r_cnt++;
        end
        awready = awvalid && (aw_cnt >= aw_dly);
        wready  = wvalid && (w_cnt >= w_dly);
        arready = arvalid && (ar_cnt >= ar_dly);
        aw_f = awvalid && awready;
        w_f  = wvalid && wready;
        ar_f = arvalid && arready;
        if (awvalid && !awready) aw_cnt++;
        if (wvalid && !wready)   w_cnt++;
        if (arvalid && !arready) ar_cnt++;
        if (aw_f) begin aw_cnt = 0; aw_obs = awaddr; end
        if (w_f)  begin w_cnt = 0; w_obs = wdata; s_obs = wstrb; end
        if (ar_f) begin ar_cnt = 0; ar_obs = araddr; end
        b_f = bvalid && bready;
        r_f = rvalid && rready;
        p_aw = awvalid; p_w = wvalid; p_ar = arvalid;
    endtask

    task automatic tick();
        @(negedge clk);
        slave_step();
    endtask

    task automatic set_dly(input int a, input int w, input int ar, input int b, input int r);
        aw_dly = a; w_dly = w; ar_dly = ar; b_dly = b; r_dly = r;
    endtask

    // Stall length follows from the slave delays: 1 idle cycle, then each request and
    // response phase lasts its delay plus one.
    task automatic txn(input bit wr, input bit rd, input bit keep, input logic [63:0] wa,
                       input logic [63:0] ra, input logic [63:0] wd, input logic [7:0] sb);
        int st, exp_st;
        exp_st = 1 + (wr ? ((aw_dly > w_dly ? aw_dly : w_dly) + 1 + b_dly + 1) : 0)
                   + (rd ? (ar_dly + 1 + r_dly + 1) : 0);
        aw_obs = '0; w_obs = '0; s_obs = '0; ar_obs = '0;
        mem_wr_en = wr; mem_rd_en = rd;
        addr_mem_wr = wa; addr_mem_rd = ra; data_mem_wr = wd; strb_mem_wr = sb;
        #1;
        chk("idle_start_no_valid", 64'({awvalid, wvalid, arvalid}), 64'd0);
        st = 0;
        while (stall_mem && st < 200) begin
            st++;
            tick();
            #1;
        end
        chk("stall_cycles", 64'(st), 64'(exp_st));
        if (wr) begin
            chk("awaddr", aw_obs, wa);
            chk("wdata", w_obs, wd);
            chk("wstrb", 64'(s_obs), 64'(sb));
`ifdef MEM_BRIDGE_ERR_EN
            exp_err |= (bresp_v != 2'b00);
`endif
        end
        if (rd) begin
            chk("araddr", ar_obs, ra);
            exp_data = rdata_v;
`ifdef MEM_BRIDGE_ERR_EN
            exp_err |= (rresp_v != 2'b00);
`endif
        end
        chk("data_mem", data_mem, exp_data);
        chk("bus_err", 64'(bus_err), 64'(exp_err));
        if (!keep) begin mem_wr_en = 0; mem_rd_en = 0; end
        tick();
    endtask

    initial begin
        int k;
        rst = 1; mem_rd_en = 0; mem_wr_en = 0;
        addr_mem_rd = 0; addr_mem_wr = 0; data_mem_wr = 0; strb_mem_wr = 0;
        exp_data = 0; exp_err = 0; bresp_v = 0; rresp_v = 0; rdata_v = 0;
        set_dly(0, 0, 0, 0, 0);
        slave_reset();
        tick(); tick();
        chk("rst_stall", 64'(stall_mem), 64'd0);
        chk("rst_data_mem", data_mem, 64'd0);
        chk("rst_bus_err", 64'(bus_err), 64'd0);
        chk("rst_valid_ready", 64'({awvalid, wvalid, arvalid, bready, rready}), 64'd0);
        chk("rst_addr", awaddr | araddr | wdata, 64'd0);
        chk("prot", 64'({awprot, arprot}), 64'd0);
        mem_rd_en = 1;
        #1 chk("rst_stall_comb", 64'(stall_mem), 64'd1);
        mem_rd_en = 0;
        tick(); rst = 0; tick();

        // zero-wait read
        rdata_v = 64'h1122334455667788; rresp_v = 2'b00; bresp_v = 2'b00;
        txn(0, 1, 0, 64'h0, 64'h80001000, 64'h0, 8'h00);
        // store with W delayed 4 cycles behind AW
        set_dly(0, 4, 0, 0, 0);
        txn(1, 0, 0, 64'h80002008, 64'h0, 64'hDEADBEEF, 8'h0F);
        // AW delayed behind W
        set_dly(3, 0, 0, 1, 0);
        txn(1, 0, 0, 64'h80003000, 64'h0, 64'h0123456789ABCDEF, 8'hF0);
        // combined store+load, zero wait
        set_dly(0, 0, 0, 0, 0);
        rdata_v = 64'hCAFEF00D12345678;
        txn(1, 1, 0, 64'h80004000, 64'h80004010, 64'h55AA55AA55AA55AA, 8'hFF);
        // error read then OKAY read
        rdata_v = 64'hBAD0BAD0BAD0BAD0; rresp_v = 2'b10;
        txn(0, 1, 0, 64'h0, 64'h80005000, 64'h0, 8'h00);
        rdata_v = 64'h0000000011110000; rresp_v = 2'b00;
        txn(0, 1, 0, 64'h0, 64'h80005008, 64'h0, 8'h00);
        // back-to-back reads, request held through DONE
        rdata_v = 64'hA1A2A3A4A5A6A7A8;
        txn(0, 1, 1, 64'h0, 64'h80006000, 64'h0, 8'h00);
        rdata_v = 64'hB1B2B3B4B5B6B7B8;
        txn(0, 1, 0, 64'h0, 64'h80006008, 64'h0, 8'h00);

        for (int i = 0; i < 40; i++) begin
            bit wr, rd, keep;
            wr = 1'($urandom_range(0, 1));
            rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
            keep = ($urandom_range(0, 3) == 0);
            set_dly($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3));
            rdata_v = {$urandom, $urandom};
            rresp_v = ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00;
            bresp_v = ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00;
            txn(wr, rd, keep, {$urandom, $urandom}, {$urandom, $urandom},
                {$urandom, $urandom}, 8'($urandom_range(0, 255)));
        end
        mem_wr_en = 0; mem_rd_en = 0;
        tick();

        // reset while waiting in RD_RESP
        set_dly(0, 0, 0, 0, 4);
        rresp_v = 2'b00; rdata_v = 64'h7777777777777777;
        mem_rd_en = 1; addr_mem_rd = 64'h80007000;
        k = 0;
        while (!rready && k < 20) begin k++; tick(); end
        chk("reached_rd_resp", 64'(rready), 64'd1);
        rst = 1; mem_rd_en = 0;
        slave_reset();
        #1;
        chk("rst_mid_valid_ready", 64'({arvalid, rready, awvalid, wvalid, bready}), 64'd0);
        chk("rst_mid_stall", 64'(stall_mem), 64'd0);
        chk("rst_mid_data_mem", data_mem, 64'd0);
        chk("rst_mid_bus_err", 64'(bus_err), 64'd0);
        exp_data = 0; exp_err = 0;
        tick(); tick(); rst = 0; tick();
        set_dly(0, 0, 0, 0, 0);
        rdata_v = 64'h0F0E0D0C0B0A0908;
        txn(0, 1, 0, 64'h0, 64'h80008000, 64'h0, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
